map_query_arbiter: RTL and testbench
====================================

MAP_QUERY_ARBITER -- requirements
Module: map_query_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of requesters (sprites) sharing one map read port.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, N_REQ bits: per-requester query request.
REQ-005 SHALL have port req_x, input, 5*N_REQ bits: tile column of requester i, in bits [5i+4:5i].
REQ-006 SHALL have port req_y, input, 5*N_REQ bits: tile row of requester i, in bits [5i+4:5i].
REQ-007 SHALL have port req_dir, input, 2*N_REQ bits: move direction of requester i (0 right, 1 left, 2 down, 3 up).
REQ-008 SHALL have port req_ack, output, N_REQ bits: one-cycle pulse when a request is accepted.
REQ-009 SHALL have port resp_valid, output, N_REQ bits: one-cycle pulse when the answer for requester i is ready.
REQ-010 SHALL have port resp_wall, output, 1 bit: 1 = target tile is wall; valid only while any resp_valid bit is set.
REQ-011 SHALL have port map_addr, output, 5 bits: row address to the map ROM port.
REQ-012 SHALL have port map_data, input, 32 bits: row word from the ROM, combinational from map_addr.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, READ and RESP.
- IDLE -> READ when any req_valid is set.
- READ -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-015 In IDLE with any req_valid set, SHALL select one winner by round-robin, starting the search at the index after the last winner.
- Pulse req_ack for that winner only.
- Latch the winner index and the target tile.
REQ-016 SHALL compute the target tile from the requester's tile and direction:
- right: x+1; left: x-1; down: y+1; up: y-1.
- All arithmetic is modulo 32 (5-bit wrap), e.g. x=0 left -> 31, y=31 down -> 0.
REQ-017 In READ, SHALL drive map_addr = target_y and register bit map_data[31 - target_x] as the wall flag.
REQ-018 In RESP, SHALL pulse resp_valid for the latched index only, with resp_wall = the registered flag.
REQ-019 SHALL have fixed timing:
- req_ack in cycle N.
- resp_valid in cycle N+2.
- Next req_ack no earlier than cycle N+3.
- Maximum throughput is one query per 3 cycles.
REQ-020 Requesters SHALL hold req_valid, x, y and dir stable until req_ack.
- Payload is sampled only in the ack cycle.
- Later changes do not affect the result.
REQ-021 A requester whose req_valid stays high after its ack SHALL be treated as a new query and granted again under round-robin.
REQ-022 Requests arriving during READ or RESP SHALL wait; none are dropped, and none are acked outside IDLE.
REQ-023 map_addr SHALL equal the latched target_y in READ and in RESP, and 0 in IDLE.
REQ-024 With all N_REQ requesting continuously, each requester SHALL be acked exactly once per N_REQ grants (no starvation).

Reset
REQ-025 When reset is high at a clock edge, SHALL:
- set state to IDLE;
- set the round-robin pointer so requester 0 has highest priority;
- clear req_ack, resp_valid, resp_wall, map_addr and busy to 0.
REQ-026 Reset asserted in READ or RESP SHALL abort the query; no resp_valid is issued for it.

Structure
REQ-027 SHALL take direction codes (DIR_RIGHT..DIR_UP), MAP_W=32 and the state encodings from shared include header map_defs.vh.
REQ-028 SHALL place round-robin selection in sub-module rr_arbiter (inputs: req vector, last-grant pointer; output: one-hot grant).
REQ-029 Top level SHALL connect map_addr/map_data to one read port of the maze ROM; the other port stays free for the renderer.

Verification
REQ-030 Single query, open tile: req 0 at (3,2) dir right, row 2 = 11110000000000001100000000000011 -> ack cycle N, resp_valid[0] at N+2, resp_wall=0.
REQ-031 Single query, wall: req 1 at (4,2) dir left -> target (3,2), resp_wall=1, only resp_valid[1] set.
REQ-032 Wrap-around:
- (0,15) dir left -> target (31,15), resp_wall=1.
- (0,15) dir right -> target (1,15), resp_wall=0.
- (5,0) dir up -> target (5,31), resp_wall=1.
REQ-033 Contention: all 4 req_valid high from the first cycle after reset -> acks 0,1,2,3 at cycles 1,4,7,10, then 0 again at 13.
REQ-034 Reset mid-operation: reset high in the READ cycle -> no resp_valid, busy=0 next cycle, next grant goes to requester 0.
REQ-035 Hold-off: req 2 is asserted during RESP of req 0 -> req_ack[2] in the following IDLE cycle, never during RESP.

Source files
------------

// File: rtl/map_query_arbiter_pkg.sv
// Shared definitions for the sprite map-query arbiter: direction codes,
// map geometry, FSM states and the tile-step helper.
package map_query_arbiter_pkg;

    localparam int MAP_W   = 32;
    localparam int COORD_W = 5;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } tile_t;

    // Neighbouring tile in the given direction; the 5-bit fields wrap modulo 32.
    function automatic tile_t step_tile(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y,
                                        input logic [1:0]         dir);
        tile_t t;
        t.x = x;
        t.y = y;
        case (dir)
            DIR_RIGHT: t.x = x + 5'd1;
            DIR_LEFT:  t.x = x - 5'd1;
            DIR_DOWN:  t.y = y + 5'd1;
            default:   t.y = y - 5'd1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/map_query_arbiter_rr_arbiter.sv
// Round-robin selector: searches from the index after the last winner
// and returns a one-hot grant (all zero when nothing requests).
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] grant
);

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/map_query_arbiter.sv
// Shares one map ROM read port among N_REQ sprites: grants one wall query
// every three cycles (ack in IDLE, ROM read in READ, answer in RESP).
module map_query_arbiter
    import map_query_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [5*N_REQ-1:0]   req_x,
    input  logic [5*N_REQ-1:0]   req_y,
    input  logic [2*N_REQ-1:0]   req_dir,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     resp_valid,
    output logic                 resp_wall,
    output logic [COORD_W-1:0]   map_addr,
    input  logic [MAP_W-1:0]     map_data,
    output logic                 busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state;
    logic [IW-1:0]      last_grant;
    logic [COORD_W-1:0] target_x;
    logic [N_REQ-1:0]   grant;
    logic [IW-1:0]      win_idx;
    tile_t              win_tile;
    logic [COORD_W-1:0] bit_idx;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .last  (last_grant),
        .grant (grant)
    );

    // Payload of the winning requester, turned into its target tile.
    always_comb begin
        win_idx  = '0;
        win_tile = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_idx  = IW'(i);
                win_tile = step_tile(req_x[5*i +: 5], req_y[5*i +: 5], req_dir[2*i +: 2]);
            end
        end
    end

    // Acks are only ever given while the read port is free.
    assign req_ack = (state == IDLE) ? grant : '0;
    assign busy    = (state != IDLE);
    assign bit_idx = 5'(MAP_W - 1) - target_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IW'(N_REQ - 1);
            target_x   <= '0;
            map_addr   <= '0;
            resp_valid <= '0;
            resp_wall  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= '0;
                    resp_wall  <= 1'b0;
                    if (|req_valid) begin
                        last_grant <= win_idx;
                        target_x   <= win_tile.x;
                        map_addr   <= win_tile.y;
                        state      <= READ;
                    end
                end
                READ: begin
                    // Column 0 is the MSB of the row word.
                    resp_wall  <= map_data[bit_idx];
                    resp_valid <= N_REQ'(1) << last_grant;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= '0;
                    resp_wall  <= 1'b0;
                    map_addr   <= '0;
                    state      <= IDLE;
                end
                default: begin
                    resp_valid <= '0;
                    resp_wall  <= 1'b0;
                    map_addr   <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_query_arbiter.sv
// Directed bench for map_query_arbiter: table of single queries against a
// small maze ROM, plus contention, mid-query reset and hold-off sequences.
module tb_map_query_arbiter;

    localparam int N_REQ = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_REQ-1:0]   req_valid;
    logic [5*N_REQ-1:0] req_x;
    logic [5*N_REQ-1:0] req_y;
    logic [2*N_REQ-1:0] req_dir;
    logic [N_REQ-1:0]   req_ack;
    logic [N_REQ-1:0]   resp_valid;
    logic               resp_wall;
    logic [4:0]         map_addr;
    logic [31:0]        map_data;
    logic               busy;

    logic [31:0] rom [32];
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int         r;
        logic [4:0] x;
        logic [4:0] y;
        logic [1:0] dir;
        logic [4:0] exp_y;
        logic       exp_wall;
    } vec_t;

    vec_t vecs [10];

    map_query_arbiter #(.N_REQ(N_REQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_dir    (req_dir),
        .req_ack    (req_ack),
        .resp_valid (resp_valid),
        .resp_wall  (resp_wall),
        .map_addr   (map_addr),
        .map_data   (map_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign map_data = rom[map_addr];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One isolated query from IDLE through RESP and back to IDLE.
    task automatic apply_stimulus(input vec_t v);
        logic [N_REQ-1:0] oh;
        oh = N_REQ'(1) << v.r;
        @(negedge clk);
        req_valid = oh;
        req_x[5*v.r +: 5]   = v.x;
        req_y[5*v.r +: 5]   = v.y;
        req_dir[2*v.r +: 2] = v.dir;
        #1;
        check_output("ack", 32'(req_ack), 32'(oh));
        check_output("busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = '0;
        req_x     = 20'($urandom);
        req_y     = 20'($urandom);
        req_dir   = 8'($urandom);
        #1;
        check_output("busy_read", 32'(busy), 32'd1);
        check_output("addr_read", 32'(map_addr), 32'(v.exp_y));
        check_output("no_resp_read", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #1;
        check_output("resp_valid", 32'(resp_valid), 32'(oh));
        check_output("resp_wall", 32'(resp_wall), 32'(v.exp_wall));
        check_output("addr_resp", 32'(map_addr), 32'(v.exp_y));
        @(negedge clk);
        #1;
        check_output("resp_clear", 32'(resp_valid), 32'd0);
        check_output("busy_back", 32'(busy), 32'd0);
        check_output("addr_idle", 32'(map_addr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h8000_0001;
        rom[0]  = 32'hFFFF_FFFF;
        rom[31] = 32'hFFFF_FFFF;
        rom[2]  = 32'b11110000000000001100000000000011;

        vecs[0] = '{0,  5'd3,  5'd2, 2'd0, 5'd2,  1'b0};
        vecs[1] = '{1,  5'd4,  5'd2, 2'd1, 5'd2,  1'b1};
        vecs[2] = '{2,  5'd0,  5'd15, 2'd1, 5'd15, 1'b1};
        vecs[3] = '{3,  5'd0,  5'd15, 2'd0, 5'd15, 1'b0};
        vecs[4] = '{0,  5'd5,  5'd0, 2'd3, 5'd31, 1'b1};
        vecs[5] = '{1,  5'd10, 5'd15, 2'd2, 5'd16, 1'b0};
        vecs[6] = '{2,  5'd16, 5'd2, 2'd0, 5'd2,  1'b1};
        vecs[7] = '{3,  5'd14, 5'd3, 2'd3, 5'd2,  1'b0};
        vecs[8] = '{0,  5'd20, 5'd31, 2'd2, 5'd0,  1'b1};
        vecs[9] = '{1,  5'd31, 5'd5, 2'd0, 5'd5,  1'b1};

        reset     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_dir   = '0;
        repeat (2) @(negedge clk);
        #1;
        check_output("rst_ack", 32'(req_ack), 32'd0);
        check_output("rst_resp", 32'(resp_valid), 32'd0);
        check_output("rst_wall", 32'(resp_wall), 32'd0);
        check_output("rst_addr", 32'(map_addr), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Contention straight out of reset: acks rotate 0,1,2,3,0 every third cycle.
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 13; c++) begin
            logic [N_REQ-1:0] exp_ack;
            logic [N_REQ-1:0] exp_resp;
            exp_ack  = (c % 3 == 0) ? N_REQ'(1) << ((c / 3) % 4) : '0;
            exp_resp = (c % 3 == 2) ? N_REQ'(1) << ((c / 3) % 4) : '0;
            #1;
            check_output("cont_ack", 32'(req_ack), 32'(exp_ack));
            check_output("cont_resp", 32'(resp_valid), 32'(exp_resp));
            @(negedge clk);
        end

        // Now in READ for requester 0; reset here must kill the response.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_resp", 32'(resp_valid), 32'd0);
        check_output("abort_addr", 32'(map_addr), 32'd0);
        check_output("abort_next_grant", 32'(req_ack), 32'd1);
        req_valid = '0;
        @(negedge clk);
        #1;
        check_output("abort_resp2", 32'(resp_valid), 32'd0);
        check_output("abort_busy2", 32'(busy), 32'd0);

        // Requester 2 raises its request during requester 0's RESP.
        req_valid = 4'b0001;
        req_x[4:0] = 5'd3;
        req_y[4:0] = 5'd2;
        req_dir[1:0] = 2'd0;
        #1;
        check_output("hold_ack0", 32'(req_ack), 32'd1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        req_valid = 4'b0100;
        req_x[14:10] = 5'd4;
        req_y[14:10] = 5'd2;
        req_dir[5:4] = 2'd1;
        #1;
        check_output("hold_no_ack_resp", 32'(req_ack), 32'd0);
        check_output("hold_resp0", 32'(resp_valid), 32'd1);
        check_output("hold_wall0", 32'(resp_wall), 32'd0);
        @(negedge clk);
        #1;
        check_output("hold_ack2", 32'(req_ack), 32'b0100);
        check_output("hold_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = '0;
        #1;
        check_output("hold_addr", 32'(map_addr), 32'd2);
        check_output("hold_no_ack_read", 32'(req_ack), 32'd0);
        @(negedge clk);
        #1;
        check_output("hold_resp2", 32'(resp_valid), 32'b0100);
        check_output("hold_wall2", 32'(resp_wall), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
